fsic_wb_target_mux: RTL

Wishbone slave-side sequencer between the Caravel management Wishbone port of the FSIC user project and four internal register targets. It decodes the master address, issues one registered request to the selected target, and returns that target's ack and read data to the master. It bounds every access with a timeout and reports unmapped or timed-out accesses as a sticky error with an interrupt.

---
 rtl/fsic_wb_target_mux.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fsic_wb_target_mux.sv
// Wishbone slave sequencer: decodes the management-port address, issues one
// registered request to one of four register targets, and returns ack/data with timeout and error capture.
module fsic_wb_target_mux #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic         wb_clk,
  input  logic         wb_rst_n,
  input  logic [31:0]  wbs_adr,
  input  logic [31:0]  wbs_wdata,
  input  logic [3:0]   wbs_sel,
  input  logic         wbs_cyc,
  input  logic         wbs_stb,
  input  logic         wbs_we,
  output logic         wbs_ack,
  output logic [31:0]  wbs_rdata,
  output logic [3:0]   tgt_stb,
  output logic         tgt_we,
  output logic [3:0]   tgt_sel,
  output logic [11:0]  tgt_adr,
  output logic [31:0]  tgt_wdata,
  input  logic [3:0]   tgt_ack,
  input  logic [127:0] tgt_rdata,
  output logic         err_irq,
  output logic [31:0]  err_addr,
  input  logic         err_clr
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

  state_t      state, state_d;
  logic [1:0]  tgt_idx;
  logic [9:0]  cnt;
  logic        mapped, hit_ack, timed_out;
  logic        launch, done_ok, done_err, abort;
  logic [31:0] err_adr_d;

  assign mapped    = (wbs_adr[31:16] == 16'h3000) && (wbs_adr[15:14] == 2'b00);
  assign hit_ack   = tgt_ack[tgt_idx];
  assign timed_out = (cnt >= TO_LAST);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state;
    launch    = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    abort     = 1'b0;
    err_adr_d = wbs_adr;
    case (state)
      IDLE: begin
        if (wbs_cyc && wbs_stb) begin
          if (mapped) begin
            launch  = 1'b1;
            state_d = REQ;
          end else begin
            done_err = 1'b1;
            state_d  = RESP;
          end
        end
      end
      REQ: begin
        // A vanished master outranks everything: nobody is left to ack.
        if (!wbs_cyc) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (hit_ack) begin
          done_ok = 1'b1;
          state_d = RESP;
        end else if (timed_out) begin
          done_err  = 1'b1;
          err_adr_d = {16'h3000, 2'b00, tgt_idx, tgt_adr};
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_d;
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wbs_ack   <= 1'b0;
      wbs_rdata <= '0;
      tgt_stb   <= '0;
      tgt_we    <= 1'b0;
      tgt_sel   <= '0;
      tgt_adr   <= '0;
      tgt_wdata <= '0;
      tgt_idx   <= '0;
      cnt       <= '0;
      err_irq   <= 1'b0;
      err_addr  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      wbs_ack <= done_ok | done_err;

      if (done_ok)       wbs_rdata <= tgt_rdata[{tgt_idx, 5'b0} +: 32];
      else if (done_err) wbs_rdata <= ERR_DATA;

      if (launch) begin
        tgt_stb   <= 4'b0001 << wbs_adr[13:12];
        tgt_idx   <= wbs_adr[13:12];
        tgt_we    <= wbs_we;
        tgt_sel   <= wbs_sel;
        tgt_adr   <= wbs_adr[11:0];
        tgt_wdata <= wbs_wdata;
        cnt       <= '0;
      end else if (state == REQ) begin
        if (done_ok || done_err || abort) tgt_stb <= '0;
        if (cnt != 10'h3FF) cnt <= cnt + 10'd1;
      end

      // A new error beats a simultaneous clear.
      if (done_err) begin
        err_irq  <= 1'b1;
        err_addr <= err_adr_d;
      end else if (err_clr) begin
        err_irq  <= 1'b0;
      end
    end
  end

endmodule
